// File: rtl/usb_rx_pkg.sv
// Shared types and helpers for the USB full-speed receive controller.
package usb_rx_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SYNC,
      S_PID_RCV,
      S_PID_CHK,
      S_WAIT,
      S_RCV,
      S_WRITE,
      S_EOP_WAIT,
      S_ERR,
      S_ERR_EOP,
      S_ERR_IDLE
   } rx_state_t;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_SYNC  = 3'd1,
      ERR_PID   = 3'd2,
      ERR_EOP   = 3'd3,
      ERR_OVF   = 3'd4,
      ERR_FULL  = 3'd5,
      ERR_STALL = 3'd6
   } err_code_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;

   // A PID byte carries its own check field: upper nibble is the ones' complement of the lower.
   function automatic logic pid_ok(input logic [7:0] pid);
      return pid[3:0] == ~pid[7:4];
   endfunction

endpackage

// File: rtl/usb_rx_stall_timer.sv
// Saturating bit-time counter; flags a stall once LIMIT increments occur without a clear.
module usb_rx_stall_timer #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);

   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != LIM)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/usb_rx_ctrl_p.sv
// USB full-speed receive control: SYNC/PID/data/EOP sequencing with PID check,
// byte-count overflow, FIFO back-pressure and stall detection, and a first-cause error code.
module usb_rx_ctrl_p
   import usb_rx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
   parameter int          MAX_BYTES    = 64,
   parameter int          TIMEOUT_BITS = 16,
   parameter int          CNT_W        = $clog2(MAX_BYTES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_edge,
   input  logic             eop,
   input  logic             shift_enable,
   input  logic [7:0]       rcv_data,
   input  logic             byte_received,
   input  logic             fifo_full,
   output logic             rcving,
   output logic             w_enable,
   output logic             r_error,
   output logic             pid_clear,
   output logic             pid_set,
   output logic             pkt_done,
   output logic [CNT_W-1:0] byte_count,
   output logic [2:0]       err_code
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

   rx_state_t        r_state, w_next;
   err_code_t        w_cause, r_err_code;
   logic [7:0]       r_pid;
   logic [CNT_W-1:0] r_count;
   logic             r_err, r_pid_clear, r_pkt_done;
   logic             w_stall, w_stall_inc, w_stall_clr, w_sync_entry, w_err_next;

   assign w_sync_entry = (w_next == S_SYNC) && (r_state != S_SYNC);
   assign w_err_next   = (w_next == S_ERR) || (w_next == S_ERR_EOP) || (w_next == S_ERR_IDLE);
   assign w_stall_inc  = shift_enable &&
                         ((r_state == S_SYNC) || (r_state == S_PID_RCV) ||
                          (r_state == S_WAIT) || (r_state == S_RCV));
   assign w_stall_clr  = byte_received || eop || w_sync_entry;

   usb_rx_stall_timer #(.LIMIT(TIMEOUT_BITS)) u_stall (
      .clk       (clk),
      .rst       (rst),
      .i_clr     (w_stall_clr),
      .i_inc     (w_stall_inc),
      .o_expired (w_stall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Error branches are ordered by priority; the stall check always comes last.
   always_comb begin
      w_next  = r_state;
      w_cause = ERR_NONE;
      case (r_state)
         S_IDLE: if (d_edge) w_next = S_SYNC;
         S_SYNC: begin
            if (byte_received) begin
               if (rcv_data == SYNC_BYTE) begin
                  w_next = S_PID_RCV;
               end else begin
                  w_next  = S_ERR;
                  w_cause = ERR_SYNC;
               end
            end else if (w_stall) begin
               w_next  = S_ERR;
               w_cause = ERR_STALL;
            end
         end
         S_PID_RCV: begin
            if (shift_enable && eop) begin
               w_next  = S_ERR_EOP;
               w_cause = ERR_EOP;
            end else if (byte_received) begin
               w_next = S_PID_CHK;
            end else if (w_stall) begin
               w_next  = S_ERR;
               w_cause = ERR_STALL;
            end
         end
         S_PID_CHK: begin
            if (pid_ok(r_pid)) begin
               w_next = S_WAIT;
            end else begin
               w_next  = S_ERR;
               w_cause = ERR_PID;
            end
         end
         S_WAIT: begin
            if (shift_enable) begin
               w_next = eop ? S_EOP_WAIT : S_RCV;
            end else if (w_stall) begin
               w_next  = S_ERR;
               w_cause = ERR_STALL;
            end
         end
         S_RCV: begin
            if (byte_received) begin
               if (r_count == MAX_CNT) begin
                  w_next  = S_ERR;
                  w_cause = ERR_OVF;
               end else if (fifo_full) begin
                  w_next  = S_ERR;
                  w_cause = ERR_FULL;
               end else begin
                  w_next = S_WRITE;
               end
            end else if (shift_enable && eop) begin
               w_next  = S_ERR_EOP;
               w_cause = ERR_EOP;
            end else if (w_stall) begin
               w_next  = S_ERR;
               w_cause = ERR_STALL;
            end
         end
         S_WRITE:    w_next = S_WAIT;
         S_EOP_WAIT: if (d_edge) w_next = S_IDLE;
         S_ERR:      if (shift_enable && eop) w_next = S_ERR_EOP;
         S_ERR_EOP:  if (d_edge) w_next = S_ERR_IDLE;
         S_ERR_IDLE: if (d_edge) w_next = S_SYNC;
         default:    w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pid       <= '0;
         r_count     <= '0;
         r_err       <= 1'b0;
         r_err_code  <= ERR_NONE;
         r_pid_clear <= 1'b0;
         r_pkt_done  <= 1'b0;
      end else begin
         r_pid_clear <= w_sync_entry;
         r_pkt_done  <= (r_state == S_WAIT) && (w_next == S_EOP_WAIT);
         if (r_state == S_PID_RCV && byte_received) r_pid <= rcv_data;
         if (w_sync_entry) begin
            r_err      <= 1'b0;
            r_err_code <= ERR_NONE;
            r_count    <= '0;
         end else begin
            if (w_err_next) r_err <= 1'b1;
            if (r_err_code == ERR_NONE && w_cause != ERR_NONE) r_err_code <= w_cause;
            if (r_state == S_WRITE && r_count != MAX_CNT) r_count <= r_count + 1'b1;
         end
      end
   end

   assign rcving     = (r_state != S_IDLE) && (r_state != S_ERR_IDLE);
   assign w_enable   = (r_state == S_WRITE);
   assign pid_set    = (r_state == S_PID_CHK) && pid_ok(r_pid);
   assign pid_clear  = r_pid_clear;
   assign pkt_done   = r_pkt_done;
   assign r_error    = r_err;
   assign err_code   = r_err_code;
   assign byte_count = r_count;

endmodule

// File: tb/tb_usb_rx_ctrl_p.sv
// Directed bench for usb_rx_ctrl_p (MAX_BYTES=4, TIMEOUT_BITS=16) with immediate-assertion checks.
module tb_usb_rx_ctrl_p;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       d_edge = 1'b0, eop = 1'b0, shift_enable = 1'b0;
   logic [7:0] rcv_data = 8'h00;
   logic       byte_received = 1'b0, fifo_full = 1'b0;
   logic       rcving, w_enable, r_error, pid_clear, pid_set, pkt_done;
   logic [2:0] byte_count;
   logic [2:0] err_code;

   int checks = 0;
   int errors = 0;
   int n_wen = 0, n_pset = 0, n_pclr = 0, n_done = 0;
   int s_wen, s_pset, s_pclr, s_done;

   always #5 clk = ~clk;

   usb_rx_ctrl_p #(.SYNC_BYTE(8'h80), .MAX_BYTES(4), .TIMEOUT_BITS(16)) dut (
      .clk(clk), .rst(rst), .d_edge(d_edge), .eop(eop), .shift_enable(shift_enable),
      .rcv_data(rcv_data), .byte_received(byte_received), .fifo_full(fifo_full),
      .rcving(rcving), .w_enable(w_enable), .r_error(r_error), .pid_clear(pid_clear),
      .pid_set(pid_set), .pkt_done(pkt_done), .byte_count(byte_count), .err_code(err_code)
   );

   always @(negedge clk) begin
      if (w_enable)  n_wen++;
      if (pid_set)   n_pset++;
      if (pid_clear) n_pclr++;
      if (pkt_done)  n_done++;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      s_wen = n_wen; s_pset = n_pset; s_pclr = n_pclr; s_done = n_done;
   endtask

   task automatic edge_pulse();
      @(posedge clk); #1 d_edge = 1'b1;
      @(posedge clk); #1 d_edge = 1'b0;
   endtask

   task automatic shift(input logic e);
      @(posedge clk); #1 shift_enable = 1'b1; eop = e;
      @(posedge clk); #1 shift_enable = 1'b0; eop = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d);
      @(posedge clk); #1 rcv_data = d; byte_received = 1'b1;
      @(posedge clk); #1 byte_received = 1'b0;
   endtask

   task automatic err_exit();
      shift(1'b1);
      edge_pulse();
      edge_pulse();
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_rcving", rcving, 0);
      chk("rst_wen", w_enable, 0);
      chk("rst_err", r_error, 0);
      chk("rst_code", err_code, 0);
      chk("rst_cnt", byte_count, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // clean packet: SYNC, PID E1, three data bytes, EOP
      snap();
      edge_pulse();
      chk("clean_pid_clear", pid_clear, 1);
      chk("clean_rcving", rcving, 1);
      send_byte(8'h80);
      send_byte(8'hE1);
      chk("clean_pid_set", pid_set, 1);
      for (int i = 0; i < 3; i++) begin
         shift(1'b0);
         send_byte(8'h10 + 8'(i));
         chk("clean_wen_lat", w_enable, 1);
      end
      shift(1'b1);
      chk("clean_pkt_done", pkt_done, 1);
      edge_pulse();
      chk("clean_idle_rcving", rcving, 0);
      chk("clean_cnt", byte_count, 3);
      chk("clean_code", err_code, 0);
      chk("clean_err", r_error, 0);
      chk("clean_n_wen", 8'(n_wen - s_wen), 3);
      chk("clean_n_pset", 8'(n_pset - s_pset), 1);
      chk("clean_n_pclr", 8'(n_pclr - s_pclr), 1);
      chk("clean_n_done", 8'(n_done - s_done), 1);

      // bad SYNC
      snap();
      edge_pulse();
      send_byte(8'h81);
      chk("sync_err", r_error, 1);
      chk("sync_code", err_code, 1);
      shift(1'b1);
      edge_pulse();
      chk("sync_erridle_rcving", rcving, 0);
      chk("sync_erridle_err", r_error, 1);
      edge_pulse();
      chk("sync_restart_err", r_error, 0);
      chk("sync_restart_code", err_code, 0);
      chk("sync_restart_pclr", pid_clear, 1);
      chk("sync_n_wen", 8'(n_wen - s_wen), 0);

      // bad PID (already in SYNC)
      snap();
      send_byte(8'h80);
      send_byte(8'hE2);
      chk("pid_bad_set", pid_set, 0);
      @(posedge clk); #1;
      chk("pid_bad_code", err_code, 2);
      chk("pid_bad_n_pset", 8'(n_pset - s_pset), 0);
      err_exit();

      // EOP during RCV mid-byte
      send_byte(8'h80);
      send_byte(8'hE1);
      shift(1'b0);
      shift(1'b1);
      chk("eop_code", err_code, 3);
      chk("eop_err", r_error, 1);
      chk("eop_rcving", rcving, 1);
      edge_pulse();
      edge_pulse();

      // overflow: five data bytes against a limit of four
      snap();
      send_byte(8'h80);
      send_byte(8'hE1);
      for (int i = 0; i < 5; i++) begin
         shift(1'b0);
         send_byte(8'h20 + 8'(i));
      end
      chk("ovf_code", err_code, 4);
      chk("ovf_cnt", byte_count, 4);
      chk("ovf_n_wen", 8'(n_wen - s_wen), 4);
      err_exit();
      chk("ovf_restart_cnt", byte_count, 0);

      // FIFO full on the second data byte
      snap();
      send_byte(8'h80);
      send_byte(8'hE1);
      shift(1'b0);
      send_byte(8'h31);
      fifo_full = 1'b1;
      shift(1'b0);
      send_byte(8'h32);
      fifo_full = 1'b0;
      chk("full_code", err_code, 5);
      chk("full_n_wen", 8'(n_wen - s_wen), 1);
      chk("full_cnt", byte_count, 1);
      err_exit();

      // stall in RCV; the later EOP must not replace the first cause
      send_byte(8'h80);
      send_byte(8'hE1);
      shift(1'b0);
      for (int i = 0; i < 20; i++) shift(1'b0);
      chk("stall_code", err_code, 6);
      chk("stall_err", r_error, 1);
      shift(1'b1);
      chk("stall_keep_code", err_code, 6);
      edge_pulse();
      edge_pulse();

      // asynchronous reset while in WRITE
      send_byte(8'h80);
      send_byte(8'hE1);
      shift(1'b0);
      send_byte(8'h41);
      chk("arst_pre_wen", w_enable, 1);
      rst = 1'b1;
      #1;
      chk("arst_wen", w_enable, 0);
      chk("arst_rcving", rcving, 0);
      chk("arst_err", r_error, 0);
      chk("arst_code", err_code, 0);
      chk("arst_pset", pid_set, 0);
      chk("arst_cnt", byte_count, 0);
      @(posedge clk); #1 rst = 1'b0;

      // clean packet after reset
      snap();
      edge_pulse();
      send_byte(8'h80);
      send_byte(8'hE1);
      for (int i = 0; i < 2; i++) begin
         shift(1'b0);
         send_byte(8'h50 + 8'(i));
      end
      shift(1'b1);
      edge_pulse();
      chk("post_cnt", byte_count, 2);
      chk("post_code", err_code, 0);
      chk("post_rcving", rcving, 0);
      chk("post_n_wen", 8'(n_wen - s_wen), 2);
      chk("post_n_done", 8'(n_done - s_done), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
